// File: rtl/axi_rd_arb.sv
// Two-requester AXI read arbiter: round-robin AR grant, one outstanding burst,
// R beats steered to the owner until rlast, with burst length / ID checking.
module axi_rd_arb #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [LEN_W-1:0]  m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [ID_W-1:0]   m0_rid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,

    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [LEN_W-1:0]  m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   m1_rid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,

    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ID_W-1:0]   s_arid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [LEN_W-1:0]  s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,

    output logic              err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic              gnt_q, gnt_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic [2:0]        arsize_q, arsize_d;
    logic [1:0]        arburst_q, arburst_d;
    logic              err_q, err_d;

    logic win;
    logic ar_hs;
    logic in_data;
    logic r_hs;

    always_comb begin
        // Contention goes to prio; otherwise whichever requester is valid.
        win        = (m0_arvalid & m1_arvalid) ? prio_q : m1_arvalid;
        ar_hs      = (state_q == StIdle) & (m0_arvalid | m1_arvalid);
        m0_arready = ar_hs & ~win;
        m1_arready = ar_hs & win;

        in_data    = (state_q == StData);
        s_rready   = in_data & (gnt_q ? m1_rready : m0_rready);
        m0_rvalid  = in_data & ~gnt_q & s_rvalid;
        m1_rvalid  = in_data & gnt_q & s_rvalid;
        r_hs       = in_data & s_rvalid & s_rready;

        s_arvalid  = (state_q == StAddr);
        s_arid     = arid_q;
        s_araddr   = araddr_q;
        s_arlen    = arlen_q;
        s_arsize   = arsize_q;
        s_arburst  = arburst_q;

        m0_rid     = s_rid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m1_rid     = s_rid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rlast   = s_rlast;
        err        = err_q;
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        beat_d    = beat_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    gnt_d     = win;
                    beat_d    = '0;
                    arid_d    = win ? m1_arid    : m0_arid;
                    araddr_d  = win ? m1_araddr  : m0_araddr;
                    arlen_d   = win ? m1_arlen   : m0_arlen;
                    arsize_d  = win ? m1_arsize  : m0_arsize;
                    arburst_d = win ? m1_arburst : m0_arburst;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (s_arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (r_hs) begin
                    beat_d = beat_q + LEN_W'(1);
                    // Errors are reported only; rlast alone ends the burst.
                    err_d  = (s_rid != arid_q)
                           | (s_rlast & (beat_q != arlen_q))
                           | (~s_rlast & (beat_q == arlen_q));
                    if (s_rlast) begin
                        state_d = StIdle;
                        prio_d  = ~gnt_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            prio_q    <= 1'b0;
            gnt_q     <= 1'b0;
            beat_q    <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            beat_q    <= beat_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Self-checking bench for axi_rd_arb: arbitration vectors, directed corner
// sequences and randomized bursts against a transaction-level model.
module tb_axi_rd_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [3:0]  f_id    [2];
    logic [63:0] f_addr  [2];
    logic [7:0]  f_len   [2];
    logic [2:0]  f_size  [2];
    logic [1:0]  f_burst [2];

    logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
    logic        m0_arready, m1_arready;
    logic [3:0]  m0_arid, m1_arid;
    logic [63:0] m0_araddr, m1_araddr;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_rvalid, m1_rvalid;
    logic        m0_rready = 1'b0, m1_rready = 1'b0;
    logic [3:0]  m0_rid, m1_rid;
    logic [63:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rlast, m1_rlast;
    logic        s_arvalid;
    logic        s_arready = 1'b0;
    logic [3:0]  s_arid;
    logic [63:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid = 1'b0;
    logic        s_rready;
    logic [3:0]  s_rid = '0;
    logic [63:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;
    logic        s_rlast = 1'b0;
    logic        err;

    assign m0_arid = f_id[0];     assign m1_arid = f_id[1];
    assign m0_araddr = f_addr[0]; assign m1_araddr = f_addr[1];
    assign m0_arlen = f_len[0];   assign m1_arlen = f_len[1];
    assign m0_arsize = f_size[0]; assign m1_arsize = f_size[1];
    assign m0_arburst = f_burst[0]; assign m1_arburst = f_burst[1];

    axi_rd_arb #(.ID_W(4), .ADDR_W(64), .DATA_W(64), .LEN_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit m_prio = 1'b0;   // model: preferred requester
    bit exp_err = 1'b0;  // model: err expected in the current cycle

    typedef struct {
        bit pre_prio;
        bit v0;
        bit v1;
        bit r0;
        bit r1;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input logic [3:0] id, input logic [63:0] addr,
                           input logic [7:0] len);
        f_id[r] = id;
        f_addr[r] = addr;
        f_len[r] = len;
        f_size[r] = 3'd3;
        f_burst[r] = 2'd1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        @(posedge clk); #1;
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_m1_arready", m1_arready, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        s_rvalid = 1'b0;
        exp_err = 1'b0;
        m_prio = 1'b0;
    endtask

    // One complete burst. Entered and left 1 time unit after a rising edge.
    // delta: beats returned = len+1+delta; rmode 0 always-ready, 1 toggling,
    // 2 random ready and rvalid; bad_beat: index returned with a wrong rid.
    task automatic burst(input bit v0, input bit v1, input int delta, input int ar_wait,
                         input int rmode, input int bad_beat);
        bit w, rr, hs, e;
        logic [3:0] id;
        logic [7:0] len;
        int i, guard, nbeats;
        m0_arvalid = v0;
        m1_arvalid = v1;
        w = (v0 && v1) ? m_prio : v1;
        #1;
        chk("arb_m0_arready", m0_arready, !w);
        chk("arb_m1_arready", m1_arready, w);
        chk("arb_err", err, exp_err);
        @(posedge clk); #1;
        exp_err = 1'b0;
        if (w) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        id = f_id[w];
        len = f_len[w];
        nbeats = int'(len) + 1 + delta;
        if (nbeats < 1) nbeats = 1;
        for (int c = 0; c <= ar_wait; c++) begin
            s_arready = (c == ar_wait);
            s_rvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
            #1;
            chk("addr_s_arvalid", s_arvalid, 1);
            chk("addr_s_arid", s_arid, id);
            chk("addr_s_araddr", s_araddr, f_addr[w]);
            chk("addr_s_arlen", s_arlen, len);
            chk("addr_s_arsize", s_arsize, f_size[w]);
            chk("addr_s_arburst", s_arburst, f_burst[w]);
            chk("addr_no_arready", {m0_arready, m1_arready}, 0);
            chk("addr_s_rready", s_rready, 0);
            chk("addr_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
            chk("addr_err", err, exp_err);
            @(posedge clk); #1;
            exp_err = 1'b0;
        end
        s_arready = 1'b0;
        i = 0;
        guard = 0;
        while (i < nbeats && guard < 200) begin
            s_rvalid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_rid = (i == bad_beat) ? id + 4'd1 : id;
            s_rdata = {$urandom, $urandom};
            s_rresp = 2'($urandom);
            s_rlast = (i == nbeats - 1);
            rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (guard % 2 == 0) : 1'($urandom);
            m0_rready = w ? 1'($urandom) : rr;
            m1_rready = w ? rr : 1'($urandom);
            #1;
            chk("data_s_rready", s_rready, rr);
            chk("data_own_rvalid", w ? m1_rvalid : m0_rvalid, s_rvalid);
            chk("data_other_rvalid", w ? m0_rvalid : m1_rvalid, 0);
            chk("data_rdata", w ? m1_rdata : m0_rdata, s_rdata);
            chk("data_rid", w ? m1_rid : m0_rid, s_rid);
            chk("data_rresp", w ? m1_rresp : m0_rresp, s_rresp);
            chk("data_rlast", w ? m1_rlast : m0_rlast, s_rlast);
            chk("data_no_arready", {m0_arready, m1_arready}, 0);
            chk("data_err", err, exp_err);
            hs = s_rvalid && rr;
            e = hs && ((s_rid != id) || (s_rlast && (i % 256) != int'(len))
                       || (!s_rlast && (i % 256) == int'(len)));
            if (hs) i++;
            guard++;
            @(posedge clk); #1;
            exp_err = e;
        end
        if (i < nbeats) begin
            n_chk++;
            n_err++;
            $display("FAIL data_timeout: delivered %0d beats, expected %0d", i, nbeats);
        end
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        m_prio = ~w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 0};
        tbl[2] = '{0, 0, 1, 0, 1};
        tbl[3] = '{0, 1, 1, 1, 0};
        tbl[4] = '{1, 1, 1, 0, 1};
        tbl[5] = '{1, 1, 0, 1, 0};
        tbl[6] = '{1, 0, 1, 0, 1};
        tbl[7] = '{1, 0, 0, 0, 0};
        set_req(0, 4'd0, 64'h0, 8'd0);
        set_req(1, 4'd0, 64'h0, 8'd0);
        #1;
        do_reset();

        // Single request from m0, then contention shows prio moved to m1
        set_req(0, 4'd3, 64'h8000_0040, 8'd7);
        set_req(1, 4'd9, 64'h1234_5678_0000_0100, 8'd2);
        burst(1, 0, 0, 0, 0, -1);
        burst(1, 1, 0, 0, 0, -1);

        // Arbitration vectors from a known prio
        foreach (tbl[k]) begin
            do_reset();
            if (tbl[k].pre_prio) begin
                set_req(0, 4'd1, 64'h40, 8'd0);
                burst(1, 0, 0, 0, 0, -1);
            end
            m0_arvalid = tbl[k].v0;
            m1_arvalid = tbl[k].v1;
            #1;
            chk($sformatf("vec%0d_m0_arready", k), m0_arready, tbl[k].r0);
            chk($sformatf("vec%0d_m1_arready", k), m1_arready, tbl[k].r1);
            m0_arvalid = 1'b0;
            m1_arvalid = 1'b0;
            @(posedge clk); #1;
        end

        // Contention from reset: 4 back-to-back bursts, order 0,1,0,1
        do_reset();
        set_req(0, 4'd2, 64'hA000, 8'd1);
        set_req(1, 4'd4, 64'hB000, 8'd2);
        repeat (4) burst(1, 1, 0, 0, 0, -1);

        // Backpressure: s_arready low 5 cycles, m1_rready toggling
        do_reset();
        set_req(1, 4'd7, 64'hC0DE_0000, 8'd3);
        burst(0, 1, 0, 5, 1, -1);

        // Length errors: short then long burst
        set_req(0, 4'd1, 64'h100, 8'd3);
        burst(1, 0, -2, 0, 0, -1);
        set_req(0, 4'd1, 64'h200, 8'd1);
        burst(1, 0, 1, 0, 0, -1);

        // ID mismatch on beat 0
        set_req(1, 4'd5, 64'h300, 8'd2);
        burst(0, 1, 0, 0, 0, 0);

        // Reset after 2 of 8 beats
        set_req(0, 4'd2, 64'h400, 8'd7);
        m0_arvalid = 1'b1;
        @(posedge clk); #1;
        m0_arvalid = 1'b0;
        s_arready = 1'b1;
        @(posedge clk); #1;
        s_arready = 1'b0;
        repeat (2) begin
            s_rvalid = 1'b1; s_rid = 4'd2; s_rlast = 1'b0; m0_rready = 1'b1;
            @(posedge clk); #1;
        end
        do_reset();
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        #1;
        chk("post_rst_prio_m0", m0_arready, 1);
        chk("post_rst_prio_m1", m1_arready, 0);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        @(posedge clk); #1;
        set_req(1, 4'd6, 64'h500, 8'd3);
        burst(0, 1, 0, 0, 0, -1);

        // Randomized bursts
        for (int t = 0; t < 40; t++) begin
            bit v0, v1;
            int delta, bad;
            for (int r = 0; r < 2; r++) begin
                set_req(r, 4'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 7)));
                f_size[r] = 3'($urandom);
                f_burst[r] = 2'($urandom);
            end
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            delta = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) - 2 : 0;
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            burst(v0, v1, delta, $urandom_range(0, 3), 2, bad);
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        #1;
        chk("final_err", err, exp_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
